// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decode handshake, forwarding taps, flush and execute handshake.
// master = surrounding pipeline, slave = the operand stage.
interface id_ex_operand_stage_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;

   logic              IN_VALID;
   logic              IN_READY;
   logic [OPC_W-1:0]  IN_OPCODE;
   logic [F3_W-1:0]   IN_FUNC3;
   logic [REG_AW-1:0] IN_RS1_ADDR;
   logic [REG_AW-1:0] IN_RS2_ADDR;
   logic [REG_AW-1:0] IN_RD_ADDR;
   logic [XLEN-1:0]   IN_RS1_RF;
   logic [XLEN-1:0]   IN_RS2_RF;
   logic [XLEN-1:0]   IN_IMM;
   logic              IN_USE_IMM;
   logic              FWD_EX_VALID;
   logic [REG_AW-1:0] FWD_EX_RD;
   logic [XLEN-1:0]   FWD_EX_DATA;
   logic              FWD_WB_VALID;
   logic [REG_AW-1:0] FWD_WB_RD;
   logic [XLEN-1:0]   FWD_WB_DATA;
   logic              FLUSH;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [OPC_W-1:0]  OUT_OPCODE;
   logic [F3_W-1:0]   FUNC3;
   logic [REG_AW-1:0] OUT_RD_ADDR;
   logic [XLEN-1:0]   RS1_DATA;
   logic [XLEN-1:0]   RS2_DATA;

   modport master (
      output IN_VALID, IN_OPCODE, IN_FUNC3, IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR,
             IN_RS1_RF, IN_RS2_RF, IN_IMM, IN_USE_IMM,
             FWD_EX_VALID, FWD_EX_RD, FWD_EX_DATA, FWD_WB_VALID, FWD_WB_RD, FWD_WB_DATA,
             FLUSH, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_OPCODE, FUNC3, OUT_RD_ADDR, RS1_DATA, RS2_DATA
   );

   modport slave (
      input  IN_VALID, IN_OPCODE, IN_FUNC3, IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR,
             IN_RS1_RF, IN_RS2_RF, IN_IMM, IN_USE_IMM,
             FWD_EX_VALID, FWD_EX_RD, FWD_EX_DATA, FWD_WB_VALID, FWD_WB_RD, FWD_WB_DATA,
             FLUSH, OUT_READY,
      output IN_READY, OUT_VALID, OUT_OPCODE, FUNC3, OUT_RD_ADDR, RS1_DATA, RS2_DATA
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: resolves forwarded operands at capture and registers them for execute.
// Optional ID_EX_SKID_BUFFER_EN adds a one-entry skid and a registered IN_READY.
module id_ex_operand_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic                  CLK,
   input logic                  RST,
   id_ex_operand_stage_if.slave bus
);
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [F3_W-1:0]   func3;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   rs1;
      logic [XLEN-1:0]   rs2;
   } payload_t;

   // EX beats WB; x0 is hardwired to zero regardless of forwarding or RF data.
   function automatic logic [XLEN-1:0] resolve(
      input logic [REG_AW-1:0] src,
      input logic [XLEN-1:0]   rf,
      input logic              ex_v,
      input logic [REG_AW-1:0] ex_rd,
      input logic [XLEN-1:0]   ex_d,
      input logic              wb_v,
      input logic [REG_AW-1:0] wb_rd,
      input logic [XLEN-1:0]   wb_d
   );
      logic [XLEN-1:0] r;
      r = rf;
      if (src == '0)                    r = '0;
      else if (ex_v && (ex_rd == src))  r = ex_d;
      else if (wb_v && (wb_rd == src))  r = wb_d;
      return r;
   endfunction

   payload_t in_pl_c;

   always_comb begin
      in_pl_c        = '0;
      in_pl_c.opcode = bus.IN_OPCODE;
      in_pl_c.func3  = bus.IN_FUNC3;
      in_pl_c.rd     = bus.IN_RD_ADDR;
      in_pl_c.rs1    = resolve(bus.IN_RS1_ADDR, bus.IN_RS1_RF,
                               bus.FWD_EX_VALID, bus.FWD_EX_RD, bus.FWD_EX_DATA,
                               bus.FWD_WB_VALID, bus.FWD_WB_RD, bus.FWD_WB_DATA);
      in_pl_c.rs2    = bus.IN_USE_IMM ? bus.IN_IMM :
                       resolve(bus.IN_RS2_ADDR, bus.IN_RS2_RF,
                               bus.FWD_EX_VALID, bus.FWD_EX_RD, bus.FWD_EX_DATA,
                               bus.FWD_WB_VALID, bus.FWD_WB_RD, bus.FWD_WB_DATA);
   end

   logic     out_valid_q, out_valid_d;
   payload_t out_q, out_d;

`ifdef ID_EX_SKID_BUFFER_EN
   logic     skid_valid_q, skid_valid_d;
   logic     in_ready_q, in_ready_d;
   payload_t skid_q, skid_d;
   logic     accept_c, out_free_c;

   assign bus.IN_READY = in_ready_q;

   // Output slot refills from the skid first so order is preserved.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      accept_c     = bus.IN_VALID && in_ready_q && !bus.FLUSH;
      out_free_c   = !out_valid_q || bus.OUT_READY;
      if (bus.FLUSH) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free_c) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept_c) begin
            out_valid_d = 1'b1;
            out_d       = in_pl_c;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         skid_valid_d = 1'b1;
         skid_d       = in_pl_c;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   logic in_ready_c, capture_c;

   assign in_ready_c   = !out_valid_q || bus.OUT_READY;
   assign bus.IN_READY = in_ready_c;

   // FLUSH wins over capture and hold; data is left untouched on drain.
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      capture_c   = bus.IN_VALID && in_ready_c && !bus.FLUSH;
      if (bus.FLUSH) begin
         out_valid_d = 1'b0;
      end else if (capture_c) begin
         out_valid_d = 1'b1;
         out_d       = in_pl_c;
      end else if (bus.OUT_READY) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign bus.OUT_VALID   = out_valid_q;
   assign bus.OUT_OPCODE  = out_q.opcode;
   assign bus.FUNC3       = out_q.func3;
   assign bus.OUT_RD_ADDR = out_q.rd;
   assign bus.RS1_DATA    = out_q.rs1;
   assign bus.RS2_DATA    = out_q.rs2;
endmodule
